// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and helpers shared by the sequential ALU
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_nbits_if.sv
// rtl/alu_seq_nbits_if.sv - operand issue and result handshake bundle
interface alu_seq_nbits_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       aluop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_res;
    logic             ZF;
    logic             SF;
    logic             CF;
    logic             OF;

    modport master (
        output in_valid, A, B, aluop, out_ready,
        input  in_ready, out_valid, alu_res, ZF, SF, CF, OF
    );

    modport slave (
        input  in_valid, A, B, aluop, out_ready,
        output in_ready, out_valid, alu_res, ZF, SF, CF, OF
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - iterative shift-add multiplier / restoring divider, WIDTH iterations
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // a_r is the shifted multiplicand for MUL and the dividend/quotient shifter for DIV/REM
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    always_comb begin
        mul_acc  = acc + (b_r[0] ? a_r : '0);
        shifted  = {acc, a_r[WIDTH-1]};
        trial    = shifted - {1'b0, b_r};
        fits     = ~trial[WIDTH];
        rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {a_r[WIDTH-2:0], fits};
    end

    // A zero divisor always fits, giving an all-ones quotient and a remainder equal to A
    assign done = busy && (count == LAST);
    assign res  = (op_r == OP_MUL)  ? mul_acc :
                  (op_r == OP_DIVU) ? quo_next : rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= '0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
        end else if (start && !busy) begin
            busy  <= 1'b1;
            count <= '0;
            op_r  <= op;
            a_r   <= A;
            b_r   <= B;
            acc   <= '0;
        end else if (busy) begin
            count <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
            if (op_r == OP_MUL) begin
                acc <= mul_acc;
                a_r <= a_r << 1;
                b_r <= b_r >> 1;
            end else begin
                acc <= rem_next;
                a_r <= quo_next;
            end
        end
    end

endmodule

// File: rtl/alu_seq_nbits.sv
// rtl/alu_seq_nbits.sv - handshaked registered ALU with iterative MUL/DIVU/REMU
module alu_seq_nbits
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    alu_seq_nbits_if.slave  bus
);
    state_t state;
    state_t state_next;

    logic             accept;
    logic             start_md;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_res;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] res_c;
    logic             sf_c;
    logic             cf_c;
    logic             of_c;

    logic [WIDTH-1:0] res_q;
    logic             zf_q;
    logic             sf_q;
    logic             cf_q;
    logic             of_q;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign start_md = accept && is_multicycle(bus.aluop) && !md_busy;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (start_md),
        .op    (bus.aluop),
        .A     (bus.A),
        .B     (bus.B),
        .busy  (md_busy),
        .done  (md_done),
        .res   (md_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = is_multicycle(bus.aluop) ? CALC : DONE;
            CALC:    if (md_done) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.alu_res   = res_q;
        bus.ZF        = zf_q;
        bus.SF        = sf_q;
        bus.CF        = cf_q;
        bus.OF        = of_q;
    end

    assign sum = {1'b0, bus.A} + {1'b0, bus.B};
    assign dif = {1'b0, bus.A} - {1'b0, bus.B};

    always_comb begin
        res_c = '0;
        sf_c  = 1'b0;
        cf_c  = 1'b0;
        of_c  = 1'b0;
        case (bus.aluop)
            OP_ADD: begin
                res_c = sum[WIDTH-1:0];
                sf_c  = sum[WIDTH-1];
                cf_c  = sum[WIDTH];
                of_c  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                res_c = dif[WIDTH-1:0];
                sf_c  = dif[WIDTH-1];
                cf_c  = dif[WIDTH];
                of_c  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  res_c = bus.A & bus.B;
            OP_OR:   res_c = bus.A | bus.B;
            OP_NOT:  res_c = ~bus.A;
            OP_XOR:  res_c = bus.A ^ bus.B;
            OP_SLL:  res_c = bus.A << bus.B[SHW-1:0];
            OP_SRL:  res_c = bus.A >> bus.B[SHW-1:0];
            OP_SRA:  res_c = WIDTH'($signed(bus.A) >>> bus.B[SHW-1:0]);
            OP_SLT:  res_c = WIDTH'($signed(bus.A) < $signed(bus.B));
            OP_SLTU: res_c = WIDTH'(bus.A < bus.B);
            default: res_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            zf_q  <= 1'b0;
            sf_q  <= 1'b0;
            cf_q  <= 1'b0;
            of_q  <= 1'b0;
        end else if (accept && !is_multicycle(bus.aluop)) begin
            res_q <= res_c;
            zf_q  <= (res_c == '0);
            sf_q  <= sf_c;
            cf_q  <= cf_c;
            of_q  <= of_c;
        end else if ((state == CALC) && md_done) begin
            res_q <= md_res;
            zf_q  <= (md_res == '0);
            sf_q  <= 1'b0;
            cf_q  <= 1'b0;
            of_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_nbits.sv
// tb/tb_alu_seq_nbits.sv - self-checking bench for alu_seq_nbits against an arithmetic reference model
module tb_alu_seq_nbits;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_seq_nbits_if #(.WIDTH(W)) bus ();

    alu_seq_nbits #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Returns {res, ZF, SF, CF, OF} from integer arithmetic on the operand values
    function automatic logic [W+3:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int ua, ub, sa, sb, r, sh, s;
        logic sf, cf, of;
        logic [W-1:0] rb;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        sh = ub % W;
        r = 0; sf = 1'b0; cf = 1'b0; of = 1'b0;
        case (op)
            4'd0: begin r = ua + ub; cf = (r > 255); s = sa + sb; of = (s > 127) || (s < -128); end
            4'd1: begin r = ua - ub; cf = (ua < ub); s = sa - sb; of = (s > 127) || (s < -128); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ~ua;
            4'd5: r = ua ^ ub;
            4'd6: r = ua << sh;
            4'd7: r = ua >> sh;
            4'd8: r = sa >>> sh;
            4'd9: r = (sa < sb) ? 1 : 0;
            4'd10: r = (ua < ub) ? 1 : 0;
            4'd11: r = ua * ub;
            4'd12: r = (ub == 0) ? 255 : ua / ub;
            4'd13: r = (ub == 0) ? ua : ua % ub;
            default: r = 0;
        endcase
        r = r & 255;
        if (op == 4'd0 || op == 4'd1) sf = (r >= 128);
        rb = r[W-1:0];
        return {rb, (rb == 8'd0), sf, cf, of};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W+3:0] exp, input string tag);
        int lat, explat;
        logic [W+3:0] got;
        explat = (op >= 4'd11 && op <= 4'd13) ? W + 1 : 1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL %s in_ready_at_issue got=%b want=1", tag, bus.in_ready);
        end
        bus.A = a; bus.B = b; bus.aluop = op; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = W'($urandom); bus.B = W'($urandom); bus.aluop = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            total++;
            if (bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL %s in_ready_busy cycle=%0d got=%b want=0", tag, lat, bus.in_ready);
            end
        end while (bus.out_valid !== 1'b1 && lat < 40);
        total++;
        if (lat != explat) begin
            bad++; $display("FAIL %s latency got=%0d want=%0d", tag, lat, explat);
        end
        got = {bus.alu_res, bus.ZF, bus.SF, bus.CF, bus.OF};
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL %s result res/zscf got=%h/%b want=%h/%b", tag, got[W+3:4], got[3:0], exp[W+3:4], exp[3:0]);
        end
    endtask

    task automatic test_reset();
        logic [W+3:0] got;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        got = {bus.alu_res, bus.ZF, bus.SF, bus.CF, bus.OF};
        total++;
        if (got !== '0) begin bad++; $display("FAIL reset outputs got=%h want=0", got); end
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset handshake got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] tbl [15];
        logic [31:0] e;
        tbl = '{32'h07F01805, 32'h10001FF6, 32'h98001010, 32'hA8001008, 32'h88003F00,
                32'hB0F11FF0, 32'hB1010008, 32'hC64070E0, 32'hD6407020, 32'hC6400FF0,
                32'hD6400640, 32'h0FF0100A, 32'hE1234008, 32'h40F00F00, 32'h180017F1};
        for (int i = 0; i < 15; i++) begin
            e = tbl[i];
            run_op(e[31:28], e[27:20], e[19:12], e[11:0], $sformatf("dir%0d", i));
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = W'($urandom);
            if ($urandom_range(0, 5) == 0) b = '0;
            run_op(op, a, b, ref_alu(op, a, b), $sformatf("rnd%0d_op%0d", i, op));
        end
    endtask

    task automatic test_backpressure();
        logic [W+3:0] exp, held, got;
        logic [W-1:0] a, b;
        a = W'($urandom); b = W'($urandom);
        exp = ref_alu(4'd0, a, b);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.A = a; bus.B = b; bus.aluop = 4'd0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        got = {bus.alu_res, bus.ZF, bus.SF, bus.CF, bus.OF};
        total++;
        if (bus.out_valid !== 1'b1 || got !== exp) begin
            bad++; $display("FAIL bp_first got valid=%b res=%h want valid=1 res=%h", bus.out_valid, got, exp);
        end
        held = got;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1; bus.aluop = 4'd1; bus.A = W'($urandom); bus.B = W'($urandom);
            @(negedge clk);
            got = {bus.alu_res, bus.ZF, bus.SF, bus.CF, bus.OF};
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || got !== held) begin
                bad++; $display("FAIL bp_hold%0d got valid=%b ready=%b res=%h want 1/0/%h", k, bus.out_valid, bus.in_ready, got, held);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        got = {bus.alu_res, bus.ZF, bus.SF, bus.CF, bus.OF};
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got !== held) begin
            bad++; $display("FAIL bp_release got valid=%b ready=%b res=%h want 0/1/%h", bus.out_valid, bus.in_ready, got, held);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [W+3:0] got;
        int seen;
        run_op(4'd0, 8'h12, 8'h34, {8'h46, 4'h0}, "pre_reset_add");
        @(negedge clk);
        bus.A = 8'h0F; bus.B = 8'h11; bus.aluop = 4'd11; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = {bus.alu_res, bus.ZF, bus.SF, bus.CF, bus.OF};
        total++;
        if (got !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_mul_reset got res=%h valid=%b ready=%b want 0/0/1", got, bus.out_valid, bus.in_ready);
        end
        rst = 1'b0;
        seen = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL aborted_mul_emitted got=%0d want=0", seen); end
        run_op(4'd11, 8'h0F, 8'h11, {8'hFF, 4'h0}, "post_reset_mul");
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.aluop = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
